// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt controller: the INTSrc select
// encodings, the interrupt sequencer states, and a state-to-select decode helper.
package cpu_pkg;

    localparam logic [1:0] INT_SRC_NONE = 2'b00;
    localparam logic [1:0] INT_SRC_NMI  = 2'b01;
    localparam logic [1:0] INT_SRC_INT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TAKE_NMI = 3'd1,
        TAKE_INT = 3'd2,
        NMI_SVC  = 3'd3,
        INT_SVC  = 3'd4
    } irq_state_t;

    function automatic logic [1:0] int_src_of(input irq_state_t s);
        case (s)
            TAKE_NMI: return INT_SRC_NMI;
            TAKE_INT: return INT_SRC_INT;
            default:  return INT_SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous pin
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/interrupt_controller.sv
// INT/NMI entry and return sequencer for the multi-cycle CPU.
// Define NMI_PREEMPT_EN to let an NMI preempt a running INT handler.
module interrupt_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       INT,
    input  logic       NMI,
    input  logic       INT_Disable,
    input  logic       instr_boundary,
    input  logic       iret,
    output logic [1:0] INTSrc,
    output logic       pc_force,
    output logic       epc_write,
    output logic       INA,
    output logic [1:0] in_service
);

    logic       w_int_sync;
    logic       w_nmi_sync;
    logic       w_nmi_edge;
    logic       w_int_req;
    logic       w_preempt_next;
    logic       r_nmi_prev;
    logic       r_nmi_pend;
    irq_state_t r_state;
    irq_state_t w_next_state;
`ifdef NMI_PREEMPT_EN
    logic       r_preempted;
`endif

    sync_2ff u_int_sync (.i_clk(clk), .i_rst(rst), .i_d(INT), .o_q(w_int_sync));
    sync_2ff u_nmi_sync (.i_clk(clk), .i_rst(rst), .i_d(NMI), .o_q(w_nmi_sync));

    assign w_nmi_edge = w_nmi_sync & ~r_nmi_prev;
    assign w_int_req  = w_int_sync & ~INT_Disable;

    // Next-state selection; a return always wins over a same-cycle boundary
    always_comb begin
        w_next_state = r_state;
`ifdef NMI_PREEMPT_EN
        w_preempt_next = r_preempted;
`else
        w_preempt_next = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (instr_boundary && r_nmi_pend) begin
                    w_next_state = TAKE_NMI;
                end else if (instr_boundary && w_int_req) begin
                    w_next_state = TAKE_INT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            TAKE_NMI: w_next_state = NMI_SVC;
            TAKE_INT: w_next_state = INT_SVC;
            INT_SVC: begin
                if (iret) begin
                    w_next_state = IDLE;
`ifdef NMI_PREEMPT_EN
                end else if (instr_boundary && r_nmi_pend) begin
                    w_next_state   = TAKE_NMI;
                    w_preempt_next = 1'b1;
`endif
                end else begin
                    w_next_state = INT_SVC;
                end
            end
            NMI_SVC: begin
                if (iret) begin
`ifdef NMI_PREEMPT_EN
                    if (r_preempted) begin
                        w_next_state   = INT_SVC;
                        w_preempt_next = 1'b0;
                    end else begin
                        w_next_state = IDLE;
                    end
`else
                    w_next_state = IDLE;
`endif
                end else begin
                    w_next_state = NMI_SVC;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, NMI pending flag and outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
            INTSrc     <= INT_SRC_NONE;
            pc_force   <= 1'b0;
            epc_write  <= 1'b0;
            INA        <= 1'b0;
            in_service <= 2'b00;
        end else begin
            r_state    <= w_next_state;
            r_nmi_prev <= w_nmi_sync;
            // an edge arriving in the take cycle is a fresh NMI, so set beats clear
            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end else if (r_state == TAKE_NMI) begin
                r_nmi_pend <= 1'b0;
            end else begin
                r_nmi_pend <= r_nmi_pend;
            end
            INTSrc     <= int_src_of(w_next_state);
            pc_force   <= (w_next_state == TAKE_NMI) || (w_next_state == TAKE_INT);
            epc_write  <= (w_next_state == TAKE_NMI) || (w_next_state == TAKE_INT);
            INA        <= (w_next_state == TAKE_INT);
            in_service <= {(w_next_state == NMI_SVC),
                           (w_next_state == INT_SVC) || w_preempt_next};
        end
    end

`ifdef NMI_PREEMPT_EN
    // Remembers that the active NMI handler interrupted an INT handler
    always_ff @(posedge clk) begin
        if (rst) begin
            r_preempted <= 1'b0;
        end else begin
            r_preempted <= w_preempt_next;
        end
    end
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized + directed bench for interrupt_controller with a handler-stack reference model.
module tb_interrupt_controller;

    localparam int K_NONE = 0;
    localparam int K_INT  = 1;
    localparam int K_NMI  = 2;

    logic       clk = 1'b0;
    logic       t_rst, t_int, t_nmi, t_dis, t_bnd, t_iret;
    logic [1:0] INTSrc;
    logic       pc_force, epc_write, INA;
    logic [1:0] in_service;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: handler stack, vector being taken, NMI pending, pin delay lines
    int   stk[$];
    int   taking;
    bit   m_pend;
    bit   nmi_line[$];
    bit   int_line[$];
    logic [1:0] e_src, e_svc;
    logic       e_pc, e_ina;

    interrupt_controller dut (
        .clk(clk), .rst(t_rst), .INT(t_int), .NMI(t_nmi), .INT_Disable(t_dis),
        .instr_boundary(t_bnd), .iret(t_iret), .INTSrc(INTSrc), .pc_force(pc_force),
        .epc_write(epc_write), .INA(INA), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        stk.delete();
        taking   = K_NONE;
        m_pend   = 1'b0;
        nmi_line = '{1'b0, 1'b0, 1'b0};
        int_line = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_outputs();
        bit has_int;
        has_int = 1'b0;
        foreach (stk[i]) if (stk[i] == K_INT) has_int = 1'b1;
        e_src = (taking == K_NMI) ? 2'b01 : (taking == K_INT) ? 2'b10 : 2'b00;
        e_pc  = (taking != K_NONE);
        e_ina = (taking == K_INT);
        e_svc = {(stk.size() > 0 && stk[$] == K_NMI && taking == K_NONE), has_int};
    endtask

    task automatic model_update();
        bit edge_s, ireq, was_take_nmi;
        if (t_rst) begin
            model_reset();
        end else begin
            edge_s       = nmi_line[1] && !nmi_line[2];
            ireq         = int_line[1] && !t_dis;
            was_take_nmi = (taking == K_NMI);
            if (taking != K_NONE) begin
                stk.push_back(taking);
                taking = K_NONE;
            end else if (stk.size() == 0) begin
                if (t_bnd && m_pend) taking = K_NMI;
                else if (t_bnd && ireq) taking = K_INT;
            end else if (t_iret) begin
                void'(stk.pop_back());
`ifdef NMI_PREEMPT_EN
            end else if (stk[$] == K_INT && t_bnd && m_pend) begin
                taking = K_NMI;
`endif
            end
            if (edge_s) m_pend = 1'b1;
            else if (was_take_nmi) m_pend = 1'b0;
            nmi_line.push_front(t_nmi);
            void'(nmi_line.pop_back());
            int_line.push_front(t_int);
            void'(int_line.pop_back());
        end
        model_outputs();
    endtask

    task automatic compare_model();
        n_vec++;
        if (INTSrc !== e_src || pc_force !== e_pc || epc_write !== e_pc ||
            INA !== e_ina || in_service !== e_svc) begin
            n_err++;
            $display("FAIL model cyc=%0d: got src=%b pcf=%b epc=%b ina=%b svc=%b expected src=%b pcf=%b epc=%b ina=%b svc=%b",
                     cyc, INTSrc, pc_force, epc_write, INA, in_service, e_src, e_pc, e_pc, e_ina, e_svc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic check_lit(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        t_rst = 1'b1; t_int = 1'b0; t_nmi = 1'b0; t_dis = 1'b0; t_bnd = 1'b0; t_iret = 1'b0;
        step();
        t_rst = 1'b0;
    endtask

    initial begin
        bit seen;
        model_reset();
        do_reset();
        check_lit("reset_src", INTSrc, 2'b00);
        check_lit("reset_take", {pc_force, epc_write}, 2'b00);
        check_lit("reset_ina_svc", {INA, in_service[0]}, 2'b00);

        // basic INT entry: pin visible to FSM only after two edges
        t_int = 1'b1;
        step();
        t_bnd = 1'b1; step();
        check_lit("int_too_early", INTSrc, 2'b00);
        step();
        check_lit("int_take_src", INTSrc, 2'b10);
        check_lit("int_take_ctl", {pc_force, epc_write}, 2'b11);
        check_lit("int_take_ina", {1'b0, INA}, 2'b01);
        t_bnd = 1'b0; step();
        check_lit("int_svc", in_service, 2'b01);
        check_lit("int_svc_src", INTSrc, 2'b00);
        t_iret = 1'b1; step();
        check_lit("int_ret", in_service, 2'b00);
        t_iret = 1'b0;

        // masked INT never taken
        do_reset();
        t_dis = 1'b1; t_int = 1'b1; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            t_bnd = (i % 4 == 3);
            step();
            if (INA || INTSrc != 2'b00) seen = 1'b1;
        end
        check_lit("masked", {1'b0, seen}, 2'b00);

        // NMI beats INT at the same boundary
        do_reset();
        t_int = 1'b1; t_nmi = 1'b1;
        step(); step(); step();
        t_bnd = 1'b1; step();
        check_lit("prio_src", INTSrc, 2'b01);
        check_lit("prio_ina", {1'b0, INA}, 2'b00);
        t_bnd = 1'b0; step();
        check_lit("prio_svc", in_service, 2'b10);
        t_iret = 1'b1; step();
        t_iret = 1'b0; t_bnd = 1'b1; step();
        check_lit("prio_int_after", INTSrc, 2'b10);
        t_bnd = 1'b0; t_int = 1'b0; t_nmi = 1'b0; step();
        t_iret = 1'b1; step(); t_iret = 1'b0;

        // NMI arriving during INT service
        do_reset();
        t_int = 1'b1; step(); step();
        t_bnd = 1'b1; step();
        t_bnd = 1'b0; t_int = 1'b0; step();
        t_nmi = 1'b1; step();
        t_nmi = 1'b0; step(); step(); step();
        t_bnd = 1'b1; step();
`ifdef NMI_PREEMPT_EN
        check_lit("preempt_src", INTSrc, 2'b01);
        t_bnd = 1'b0; step();
        check_lit("preempt_svc", in_service, 2'b11);
        t_iret = 1'b1; step();
        check_lit("preempt_ret1", in_service, 2'b01);
        step();
        check_lit("preempt_ret2", in_service, 2'b00);
        t_iret = 1'b0;
`else
        check_lit("nopreempt_src", INTSrc, 2'b00);
        t_bnd = 1'b0; t_iret = 1'b1; step();
        check_lit("nopreempt_ret", in_service, 2'b00);
        t_iret = 1'b0; t_bnd = 1'b1; step();
        check_lit("nopreempt_nmi", INTSrc, 2'b01);
        t_bnd = 1'b0; step();
        t_iret = 1'b1; step(); t_iret = 1'b0;
`endif

        // two close NMI edges merge into one take
        do_reset();
        t_nmi = 1'b1; step(); t_nmi = 1'b0; step(); t_nmi = 1'b1; step(); t_nmi = 1'b0;
        step(); step(); step();
        t_bnd = 1'b1; step();
        check_lit("merge_take", INTSrc, 2'b01);
        t_bnd = 1'b0; step();
        t_iret = 1'b1; step(); t_iret = 1'b0;
        t_bnd = 1'b1; step(); step();
        check_lit("merge_single", INTSrc, 2'b00);

        // reset during TAKE_INT discards an NMI already in the synchronizer
        do_reset();
        t_int = 1'b1; step(); step(); step();
        t_nmi = 1'b1; t_bnd = 1'b1; step();
        check_lit("rst_take", INTSrc, 2'b10);
        t_rst = 1'b1; t_nmi = 1'b0; t_int = 1'b0; t_bnd = 1'b0; step();
        check_lit("rst_out_src", INTSrc, 2'b00);
        check_lit("rst_out_ctl", {pc_force, INA}, 2'b00);
        check_lit("rst_out_svc", in_service, 2'b00);
        t_rst = 1'b0; t_bnd = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_lit("rst_no_pend", INTSrc, 2'b00);
        t_bnd = 1'b0;

        // randomized traffic checked against the model every cycle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            t_rst  = ($urandom_range(0, 499) == 0);
            t_bnd  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) t_int = ~t_int;
            if ($urandom_range(0, 7) == 0) t_nmi = ~t_nmi;
            if ($urandom_range(0, 29) == 0) t_dis = ~t_dis;
            t_iret = (stk.size() > 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
